// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters, indexed by PC word address.
// Predicts at fetch (combinational read) and trains from execute-stage branch resolutions.
// Flags mispredicts one cycle after resolution and keeps saturating hit/miss statistics.
// Optional feature: define BP_GHR_EN to XOR both indices with an IDX_W-bit global history.
module branch_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_is_branch,
  output logic             pred_taken,
  output logic             ready,
  input  logic             res_valid,
  input  logic [PC_W-1:0]  res_pc,
  input  logic [3:0]       res_ctl,
  input  logic             res_taken,
  input  logic             res_pred,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned Entries = 1 << IDX_W;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       table_q [Entries];
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] pidx, ridx;
  logic             ctl_is_branch;
  logic             accepted;
  logic [1:0]       cnt_cur, cnt_new;

  // Only the word-address bits select an entry; the rest of each PC is intentionally dropped.
  logic unused_pc;
  assign unused_pc = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0],
                       res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

`ifdef BP_GHR_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign pidx = fetch_pc[IDX_W+1:2] ^ ghr_q;
  assign ridx = res_pc[IDX_W+1:2] ^ ghr_q;

  // History shifts in the resolved outcome; prediction this cycle still sees the old value.
  always_comb begin
    ghr_d = ghr_q;
    if (accepted) begin
      ghr_d = {ghr_q[IDX_W-2:0], res_taken};
    end
  end

  // History register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign pidx = fetch_pc[IDX_W+1:2];
  assign ridx = res_pc[IDX_W+1:2];
`endif

  assign ready      = (state_q == StRun);
  assign pred_taken = ready & fetch_is_branch & table_q[pidx][1];
  assign mispredict = mispredict_q;
  assign br_cnt     = br_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // Decode which control codes are conditional branches worth training on.
  always_comb begin
    ctl_is_branch = 1'b0;
    case (res_ctl)
      4'b0111, 4'b1011, 4'b1100, 4'b1101: ctl_is_branch = 1'b1;
      default:                            ctl_is_branch = 1'b0;
    endcase
  end

  assign accepted = ready & res_valid & ctl_is_branch;

  // Saturating counter step for the resolved entry.
  always_comb begin
    cnt_cur = table_q[ridx];
    cnt_new = cnt_cur;
    if (res_taken) begin
      if (cnt_cur != 2'b11) cnt_new = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_new = cnt_cur - 2'b01;
    end
  end

  // Next-state: sweep one entry per cycle in StInit, then stay in StRun until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == {IDX_W{1'b1}}) state_d = StRun;
      end
      StRun: begin
        ptr_d = ptr_q;
      end
      default: state_d = StInit;
    endcase
  end

  // Mispredict flag and statistics, both counters stick at all-ones.
  always_comb begin
    mispredict_d = accepted & (res_taken != res_pred);
    br_cnt_d     = br_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (accepted && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispredict_d && (miss_cnt_q != {CNT_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // Control and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      mispredict_q <= 1'b0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      mispredict_q <= mispredict_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Counter table: no reset, contents are established by the init sweep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        table_q[ptr_q] <= 2'b01;
      end else if (accepted) begin
        table_q[ridx] <= cnt_new;
      end
    end
  end

endmodule
